// File: rtl/beat_packer.sv
// Serial-to-parallel packer: gathers Count beats of Width bits into one word
// held in a single-entry valid/ready output register.
module beat_packer #(
  parameter int unsigned Width = 1,
  parameter int unsigned Count = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       valid_i,
  input  logic [Width-1:0]                           data_i,
  output logic                                       ready_o,
  input  logic                                       flush_i,
  output logic                                       valid_o,
  output logic [Width*Count-1:0]                     data_o,
  input  logic                                       ready_i,
  output logic [((Count > 1) ? $clog2(Count) : 1)-1:0] count_o
);

  localparam int unsigned CntW  = (Count > 1) ? $clog2(Count) : 1;
  localparam int unsigned DataW = Width * Count;
  localparam int unsigned AccW  = (Count > 1) ? (Count - 1) * Width : Width;
  localparam logic [CntW-1:0] LastCnt = CntW'(Count - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [DataW-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [DataW-1:0] word_c;
  logic             last_c;
  logic             accept_c;

  assign last_c   = (cnt_q == LastCnt);
  // The final beat may only enter when the output slot is free or draining now.
  assign ready_o  = !flush_i && (!last_c || !valid_q || ready_i);
  assign accept_c = valid_i && ready_o;

  generate
    if (Count > 1) begin : g_multi
      assign word_c = {data_i, acc_q};
    end else begin : g_single
      assign word_c = data_i;
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (accept_c) begin
      if (last_c) begin
        data_d  = word_c;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        for (int unsigned k = 0; k + 1 < Count; k++) begin
          if (cnt_q == CntW'(k)) begin
            acc_d[k*Width +: Width] = data_i;
          end
        end
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Flush discards only the partial word; the output register is untouched.
    if (flush_i) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_beat_packer.sv
// Directed and scoreboard checks for beat_packer in a 8x4 and a 1x1 configuration.
module tb_beat_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;

  logic        valid_a, ready_o_a, flush_a, valid_o_a, ready_a;
  logic [7:0]  data_a;
  logic [31:0] data_o_a;
  logic [1:0]  count_o_a;

  logic        valid_b, ready_o_b, flush_b, valid_o_b, ready_b;
  logic [0:0]  data_b, data_o_b, count_o_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  beat_packer #(.Width(8), .Count(4)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_a), .data_i(data_a),
    .ready_o(ready_o_a), .flush_i(flush_a), .valid_o(valid_o_a),
    .data_o(data_o_a), .ready_i(ready_a), .count_o(count_o_a)
  );

  beat_packer #(.Width(1), .Count(1)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_o_b), .flush_i(flush_b), .valid_o(valid_o_b),
    .data_o(data_o_b), .ready_i(ready_b), .count_o(count_o_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [7:0]  beats [4];
  logic [7:0]  m_part [3];
  logic [1:0]  m_cnt;
  logic        m_valid, exp_ready;
  logic [31:0] m_word;

  initial begin
    rst_ni  = 1'b0;
    valid_a = 1'b0; data_a = '0; flush_a = 1'b0; ready_a = 1'b0;
    valid_b = 1'b0; data_b = '0; flush_b = 1'b0; ready_b = 1'b0;
    #12 rst_ni = 1'b1;
    #1;
    check("rst_valid", 64'(valid_o_a), 64'd0);
    check("rst_data",  64'(data_o_a),  64'd0);
    check("rst_count", 64'(count_o_a), 64'd0);
    check("rst_ready", 64'(ready_o_a), 64'd1);
    check("rst_valid_b", 64'(valid_o_b), 64'd0);

    // Basic packing with ready_i held high
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    ready_a = 1'b1;
    valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_a = beats[i];
      #1;
      check("seq_count", 64'(count_o_a), 64'(i));
      check("seq_ready", 64'(ready_o_a), 64'd1);
      tick();
    end
    check("seq_valid", 64'(valid_o_a), 64'd1);
    check("seq_data",  64'(data_o_a),  64'h44332211);
    check("seq_count_wrap", 64'(count_o_a), 64'd0);
    valid_a = 1'b0;
    tick();
    check("seq_drain", 64'(valid_o_a), 64'd0);

    // Backpressure: first word held, final beat of second word stalls
    ready_a = 1'b0;
    valid_a = 1'b1;
    beats = '{8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 4; i++) begin
      data_a = beats[i];
      tick();
    end
    check("bp_first_valid", 64'(valid_o_a), 64'd1);
    check("bp_first_data",  64'(data_o_a),  64'h14131211);
    beats = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 3; i++) begin
      data_a = beats[i];
      #1;
      check("bp_nonfinal_ready", 64'(ready_o_a), 64'd1);
      tick();
    end
    data_a = 8'h88;
    #1;
    check("bp_final_stall", 64'(ready_o_a), 64'd0);
    tick();
    check("bp_hold_data",  64'(data_o_a),  64'h14131211);
    check("bp_hold_valid", 64'(valid_o_a), 64'd1);
    check("bp_hold_count", 64'(count_o_a), 64'd3);
    ready_a = 1'b1;
    #1;
    check("bp_release_ready", 64'(ready_o_a), 64'd1);
    tick();
    check("bp_second_data",  64'(data_o_a),  64'h88776655);
    check("bp_no_bubble",    64'(valid_o_a), 64'd1);
    check("bp_second_count", 64'(count_o_a), 64'd0);
    valid_a = 1'b0;
    tick();
    check("bp_drain", 64'(valid_o_a), 64'd0);

    // Flush discards the partial word and refuses the concurrent beat
    valid_a = 1'b1;
    data_a = 8'hAA; tick();
    data_a = 8'hBB; tick();
    flush_a = 1'b1; data_a = 8'hCC;
    #1;
    check("flush_ready", 64'(ready_o_a), 64'd0);
    tick();
    flush_a = 1'b0;
    check("flush_count", 64'(count_o_a), 64'd0);
    beats = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      data_a = beats[i];
      tick();
    end
    check("flush_word", 64'(data_o_a), 64'h04030201);

    // Asynchronous reset with a partial word and a pending output
    ready_a = 1'b0;
    data_a = 8'h21; tick();
    data_a = 8'h22; tick();
    valid_a = 1'b0;
    check("pre_rst_count", 64'(count_o_a), 64'd2);
    check("pre_rst_valid", 64'(valid_o_a), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", 64'(valid_o_a), 64'd0);
    check("arst_data",  64'(data_o_a),  64'd0);
    check("arst_count", 64'(count_o_a), 64'd0);
    #2 rst_ni = 1'b1;
    ready_a = 1'b1;
    valid_a = 1'b1;
    beats = '{8'h31, 8'h32, 8'h33, 8'h34};
    for (int i = 0; i < 4; i++) begin
      data_a = beats[i];
      tick();
    end
    check("post_rst_word",  64'(data_o_a),  64'h34333231);
    check("post_rst_valid", 64'(valid_o_a), 64'd1);
    valid_a = 1'b0;
    tick();

    // Width=1, Count=1 behaves as a one-entry pipeline register
    ready_b = 1'b1;
    valid_b = 1'b1;
    data_b = 1'b1; tick();
    check("deg_bit0", 64'(data_o_b), 64'd1);
    check("deg_v0",   64'(valid_o_b), 64'd1);
    data_b = 1'b0; tick();
    check("deg_bit1", 64'(data_o_b), 64'd0);
    check("deg_v1",   64'(valid_o_b), 64'd1);
    data_b = 1'b1; tick();
    check("deg_bit2", 64'(data_o_b), 64'd1);
    check("deg_v2",   64'(valid_o_b), 64'd1);
    check("deg_count", 64'(count_o_b), 64'd0);
    valid_b = 1'b0;
    ready_b = 1'b0;
    #1;
    check("deg_stall_ready", 64'(ready_o_b), 64'd0);
    tick();
    check("deg_hold_valid", 64'(valid_o_b), 64'd1);
    check("deg_hold_data",  64'(data_o_b),  64'd1);

    // Random soak against a reference model of the packer
    m_cnt = 2'd0;
    m_valid = 1'b0;
    m_word = 32'h34333231;
    m_part = '{8'h0, 8'h0, 8'h0};
    for (int n = 0; n < 400; n++) begin
      valid_a = 1'($urandom_range(0, 1));
      data_a  = 8'($urandom);
      ready_a = ($urandom_range(0, 9) < 6);
      flush_a = ($urandom_range(0, 31) == 0);
      #1;
      exp_ready = !flush_a && ((m_cnt != 2'd3) || !m_valid || ready_a);
      check("soak_ready", 64'(ready_o_a), 64'(exp_ready));
      check("soak_valid", 64'(valid_o_a), 64'(m_valid));
      check("soak_data",  64'(data_o_a),  64'(m_word));
      check("soak_count", 64'(count_o_a), 64'(m_cnt));
      if (valid_a && exp_ready && m_cnt == 2'd3) begin
        m_word  = {data_a, m_part[2], m_part[1], m_part[0]};
        m_valid = 1'b1;
        m_cnt   = 2'd0;
      end else begin
        if (m_valid && ready_a) m_valid = 1'b0;
        if (valid_a && exp_ready) begin
          m_part[m_cnt] = data_a;
          m_cnt = m_cnt + 2'd1;
        end
      end
      if (flush_a) begin
        m_cnt = 2'd0;
        m_part = '{8'h0, 8'h0, 8'h0};
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
